// File: rtl/imem_sync.sv
// Synchronous instruction memory: one-cycle registered fetch with valid/ready, stall hold, flush,
// fault flag, program-load write port and optional post-reset zero-fill.
module imem_sync #(
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    DATA_WIDTH     = 32,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD       = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_fault,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-3:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  init_done
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_fault_q, resp_fault_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  accept, hold, req_fault;
    logic [IDX_W-1:0]      req_idx;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign req_idx   = req_addr[ADDR_WIDTH-1:2];
    // Shift form keeps the range test legal even when ADDR_WIDTH covers the full address.
    assign req_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> ADDR_WIDTH) != 32'd0);

    assign req_ready = ~rst && (state_q == ST_RUN) && ~load_we &&
                       (~resp_valid_q || ~stall || flush);
    assign accept    = req_valid && req_ready;
    assign hold      = resp_valid_q && stall && ~flush;

    assign mem_we    = ~rst && ((state_q == ST_CLEAR) || load_we);
    assign mem_widx  = (state_q == ST_CLEAR) ? clr_cnt_q : load_addr;
    assign mem_wdata = (state_q == ST_CLEAR) ? NOP_WORD : load_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        init_done_d  = init_done_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;

        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end

        // Accept and hold are mutually exclusive because hold forces req_ready low.
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_fault_d = req_fault;
            resp_data_d  = req_fault ? NOP_WORD : mem_q[req_idx];
        end else if (!hold) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q    <= '0;
            init_done_q  <= ~CLEAR_ON_RESET;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            init_done_q  <= init_done_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_fault = resp_fault_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_imem_sync.sv
// Directed bench for imem_sync: zero-fill instance (A) and retain-on-reset instance (B).
module tb_imem_sync;

    logic        clk = 1'b0;
    logic        rst, rst_b;
    logic        req_valid, stall, flush, load_we;
    logic [31:0] req_addr, load_data;
    logic [7:0]  load_addr;

    logic        req_ready_a, resp_valid_a, resp_fault_a, init_done_a;
    logic [31:0] resp_data_a;
    logic        req_ready_b, resp_valid_b, resp_fault_b, init_done_b;
    logic [31:0] resp_data_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_sync #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b1), .NOP_WORD(32'h0)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready_a),
        .resp_valid(resp_valid_a), .resp_data(resp_data_a), .resp_fault(resp_fault_a),
        .stall(stall), .flush(flush), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .init_done(init_done_a)
    );

    imem_sync #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b0), .NOP_WORD(32'h0)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready_b),
        .resp_valid(resp_valid_b), .resp_data(resp_data_b), .resp_fault(resp_fault_b),
        .stall(stall), .flush(flush), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .init_done(init_done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until init_done rises (bounded); also flags any req_ready while clearing.
    task automatic wait_init(output int n, output int rdy_bad);
        n = 0;
        rdy_bad = 0;
        while (n < 400) begin
            #1;
            if (req_ready_a !== 1'b0) rdy_bad++;
            cyc();
            n++;
            if (init_done_a === 1'b1) break;
        end
    endtask

    initial begin
        int n, bad;

        rst = 1'b1; rst_b = 1'b1;
        req_valid = 1'b0; req_addr = 32'h0; stall = 1'b0; flush = 1'b0;
        load_we = 1'b0; load_addr = 8'd0; load_data = 32'h0;
        cyc(); cyc();
        #1;
        chk("rst_resp_valid", resp_valid_a, 1'b0);
        chk("rst_resp_data", resp_data_a, 32'h0);
        chk("rst_resp_fault", resp_fault_a, 1'b0);
        chk("rst_init_done", init_done_a, 1'b0);
        chk("rst_req_ready", req_ready_a, 1'b0);
        chk("rst_b_init_done", init_done_b, 1'b1);

        // Zero-fill: init_done 256 edges after release, no ready meanwhile.
        rst = 1'b0; rst_b = 1'b0;
        req_valid = 1'b1; req_addr = 32'h18;
        wait_init(n, bad);
        chk("clear_cycles", n, 256);
        chk("clear_no_ready", bad, 0);

        // Every word reads back zero, streamed back-to-back.
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            req_valid = 1'b1; req_addr = i * 4;
            cyc();
            if (resp_valid_a !== 1'b1 || resp_data_a !== 32'h0 || resp_fault_a !== 1'b0) bad++;
        end
        chk("fill_zero_words", bad, 0);

        // Program load blocks fetch; fetch right after the load sees the new word.
        req_valid = 1'b1; req_addr = 32'h18;
        load_we = 1'b1; load_addr = 8'd6; load_data = 32'h012a4020;
        #1 chk("load_blocks_ready", req_ready_a, 1'b0);
        cyc();
        load_addr = 8'd7; load_data = 32'h00851820;
        cyc();
        load_we = 1'b0; req_addr = 32'h1c;
        cyc();
        chk("ld7_valid", resp_valid_a, 1'b1);
        chk("ld7_data", resp_data_a, 32'h00851820);
        req_addr = 32'h18;
        cyc();
        chk("b2b0_data", resp_data_a, 32'h012a4020);
        chk("b2b0_fault", resp_fault_a, 1'b0);
        req_addr = 32'h1c;
        cyc();
        chk("b2b1_valid", resp_valid_a, 1'b1);
        chk("b2b1_data", resp_data_a, 32'h00851820);

        // Faults: misaligned, past the top, high address bit.
        req_addr = 32'h1a;
        cyc();
        chk("mis_fault", resp_fault_a, 1'b1);
        chk("mis_data", resp_data_a, 32'h0);
        req_addr = 32'h400;
        cyc();
        chk("oor_fault", resp_fault_a, 1'b1);
        chk("oor_valid", resp_valid_a, 1'b1);
        req_addr = 32'h8000_0000;
        cyc();
        chk("hi_fault", resp_fault_a, 1'b1);
        req_valid = 1'b0;
        cyc();
        chk("idle_valid", resp_valid_a, 1'b0);
        chk("idle_fault_kept", resp_fault_a, 1'b1);

        // Stall hold for 3 cycles; a load to the held word does not alter the response.
        req_valid = 1'b1; req_addr = 32'h18;
        cyc();
        stall = 1'b1; req_addr = 32'h1c;
        for (int i = 0; i < 3; i++) begin
            load_we = (i == 1); load_addr = 8'd6; load_data = 32'h11112222;
            #1 chk("stall_ready", req_ready_a, 1'b0);
            cyc();
            chk("stall_valid", resp_valid_a, 1'b1);
            chk("stall_data", resp_data_a, 32'h012a4020);
        end
        load_we = 1'b0; stall = 1'b0;
        #1 chk("unstall_ready", req_ready_a, 1'b1);
        cyc();
        chk("unstall_data", resp_data_a, 32'h00851820);

        // Flush with redirect under stall, then flush alone.
        req_addr = 32'h18;
        cyc();
        chk("reload6_data", resp_data_a, 32'h11112222);
        stall = 1'b1; flush = 1'b1; req_addr = 32'h1c;
        #1 chk("flush_ready", req_ready_a, 1'b1);
        cyc();
        chk("redirect_valid", resp_valid_a, 1'b1);
        chk("redirect_data", resp_data_a, 32'h00851820);
        req_valid = 1'b0;
        cyc();
        chk("flush_only_valid", resp_valid_a, 1'b0);
        stall = 1'b0; flush = 1'b0;

        // Reset during a fetch drops it; reset mid-clear restarts the full clear.
        req_valid = 1'b1; req_addr = 32'h18; rst = 1'b1;
        #1 chk("rst_fetch_ready", req_ready_a, 1'b0);
        cyc();
        chk("rst_fetch_valid", resp_valid_a, 1'b0);
        chk("rst_fetch_data", resp_data_a, 32'h0);
        rst = 1'b0; req_valid = 1'b0;
        repeat (100) cyc();
        chk("mid_clear_init", init_done_a, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wait_init(n, bad);
        chk("reclear_cycles", n, 256);
        req_valid = 1'b1; req_addr = 32'h18;
        cyc();
        chk("reclear_word6", resp_data_a, 32'h0);

        // Retain-on-reset instance keeps loaded words and is ready at once.
        req_valid = 1'b0;
        load_we = 1'b1; load_addr = 8'd9; load_data = 32'hcafef00d;
        cyc();
        load_we = 1'b0; rst_b = 1'b1;
        cyc();
        chk("b_init_after_rst", init_done_b, 1'b1);
        chk("b_valid_after_rst", resp_valid_b, 1'b0);
        rst_b = 1'b0; req_valid = 1'b1; req_addr = 32'h24;
        #1 chk("b_ready_after_rst", req_ready_b, 1'b1);
        cyc();
        chk("b_word9", resp_data_b, 32'hcafef00d);
        req_addr = 32'h18;
        cyc();
        chk("b_word6", resp_data_b, 32'h11112222);
        req_valid = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
